// File: rtl/sky130_fd_io__xres_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__xres_pulse_gen
// Description : Core-side driver for an external active-low open-drain reset
//               line (XRES pad). On request, it pulls the pad low for a fixed
//               number of cycles, which is wider than the receiver's filter
//               window. It then releases the pad and confirms the release
//               through a synchronised readback. A recovery gap follows before
//               the sequence is acknowledged. A line that fails to rise within
//               the timeout is flagged as stuck.
//
// Ports       : i_clk          single clock, all state on rising edge
//               i_reset_b      asynchronous active-low reset
//               i_req          level request for one reset pulse
//               o_ack          1-cycle pulse, sequence complete
//               o_busy         high in every state except IDLE
//               o_pad_drv_lo   1 = pull pad low (open-drain enable)
//               i_pad_in       asynchronous pad readback
//               o_stuck_err    sticky, line failed to rise in time
//               i_clr_err      clears o_stuck_err, leaves FAULT
//               o_ext_rst_det  1-cycle pulse, external low seen in IDLE
//
// Option      : SKY130_FD_IO_XRES_PULSE_GEN_EXT_DETECT_EN enables the
//               external-reset detector. When it is undefined, o_ext_rst_det
//               is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_fd_io__xres_pulse_gen #(
  parameter int PULSE_CYCLES   = 64,
  parameter int RECOVER_CYCLES = 32,
  parameter int STUCK_CYCLES   = 256,
  parameter int SYNC_STAGES    = 2,
  parameter int EXT_MIN_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_reset_b,
  input  logic i_req,
  output logic o_ack,
  output logic o_busy,
  output logic o_pad_drv_lo,
  input  logic i_pad_in,
  output logic o_stuck_err,
  input  logic i_clr_err,
  output logic o_ext_rst_det
);

  // One shared down-counter covers every timed interval, so it is sized
  // for the longest of them.
  localparam int c_MAX_A = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
  localparam int c_MAX_B = (STUCK_CYCLES > EXT_MIN_CYCLES) ? STUCK_CYCLES : EXT_MIN_CYCLES;
  localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CNT_W = $clog2(c_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_PULSE_LD   = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_RECOVER_LD = c_CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STUCK_LD   = c_CNT_W'(STUCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASSERT  = 3'd1,
    S_RELEASE = 3'd2,
    S_RECOVER = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_pad_drv_lo;
  logic                 r_ack;
  logic                 r_busy;
  logic                 r_stuck_err;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 w_pad_s;

  // The synchroniser resets to 1 so that a released line is assumed, and no
  // false low is seen straight out of reset.
  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_in};
    end
  end

  assign w_pad_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pad_drv_lo <= 1'b0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_stuck_err  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      // A clear outside FAULT only drops the flag. A timeout on the same edge
      // is written later in this block, so the timeout takes priority.
      if (i_clr_err && (r_state != S_FAULT)) begin
        r_stuck_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_state      <= S_ASSERT;
            r_cnt        <= c_PULSE_LD;
            r_pad_drv_lo <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (r_cnt == '0) begin
            r_state      <= S_RELEASE;
            r_cnt        <= c_STUCK_LD;
            r_pad_drv_lo <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (w_pad_s) begin
            r_state <= S_RECOVER;
            r_cnt   <= c_RECOVER_LD;
            // A one-cycle recovery makes its first cycle also its last.
            r_ack   <= (RECOVER_CYCLES == 1);
          end else if (r_cnt == '0) begin
            r_state     <= S_FAULT;
            r_stuck_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        S_RECOVER: begin
          // ACK is high during the final recovery cycle. BUSY drops on the
          // following cycle, which is also the first cycle in which a held
          // REQ is sampled again.
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            r_ack <= (r_cnt == c_CNT_W'(1));
          end
        end
        S_FAULT: begin
          if (i_clr_err) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_stuck_err <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_pad_drv_lo <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_busy       = r_busy;
  assign o_pad_drv_lo = r_pad_drv_lo;
  assign o_stuck_err  = r_stuck_err;

`ifdef SKY130_FD_IO_XRES_PULSE_GEN_EXT_DETECT_EN
  localparam logic [c_CNT_W-1:0] c_EXT_LD = c_CNT_W'(EXT_MIN_CYCLES - 1);

  logic [c_CNT_W-1:0] r_ext_cnt;
  logic               r_ext_fired;
  logic               r_ext_rst_det;

  // Counts consecutive low samples in IDLE only, so our own pulses can never
  // trigger it. r_ext_fired limits the flag to one pulse per low episode,
  // and it re-arms once the line is seen high.
  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_ext_cnt     <= '0;
      r_ext_fired   <= 1'b0;
      r_ext_rst_det <= 1'b0;
    end else begin
      r_ext_rst_det <= 1'b0;
      if (w_pad_s) begin
        r_ext_cnt   <= '0;
        r_ext_fired <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_ext_cnt <= '0;
      end else if (!r_ext_fired) begin
        if (r_ext_cnt == c_EXT_LD) begin
          r_ext_rst_det <= 1'b1;
          r_ext_fired   <= 1'b1;
        end else begin
          r_ext_cnt <= r_ext_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  assign o_ext_rst_det = r_ext_rst_det;
`else
  assign o_ext_rst_det = 1'b0;
`endif

endmodule
`default_nettype wire
